// File: rtl/dice_roll_ctrl.sv
// Dice roll sequencer: synchronizes and debounces six die-select buttons, grants one
// roll at a time, drives the BCD counter through a hold phase and a decelerating coast,
// then flags the settled result.
module dice_roll_ctrl #(
    parameter int unsigned DEB_CYCLES  = 64,
    parameter int unsigned COAST_STEPS = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] btn_raw,
    output logic [2:0] die_sel,
    output logic       cnt_load,
    output logic       cnt_step,
    output logic       busy,
    output logic       result_valid
);

    localparam logic [7:0] DebLast   = 8'(DEB_CYCLES - 1);
    localparam logic [3:0] StepsLast = 4'(COAST_STEPS - 1);

    typedef enum logic [1:0] {StIdle, StRoll, StCoast, StShow} state_e;

    logic [5:0]      r_sync1;
    logic [5:0]      r_sync2;
    logic [5:0]      r_db;
    logic [5:0]      r_db_prev;
    logic [5:0]      r_pe;
    logic [5:0][7:0] r_stab;
    logic [5:0]      w_db_d;
    logic [5:0][7:0] w_stab_d;

    state_e          r_state;
    state_e          w_state_d;
    logic [2:0]      r_die_sel;
    logic            r_load;
    logic [7:0]      r_interval;
    logic [7:0]      r_wait;
    logic [3:0]      r_steps;

    logic [2:0]      w_grant;
    logic            w_any_pe;
    logic            w_start;
    logic            w_db_g;
    logic            w_coast_pulse;
    logic [7:0]      w_interval_next;

    // Two-flop synchronizer on every button.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= btn_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Debounce next level: flip only after DEB_CYCLES consecutive differing samples.
    always_comb begin
        w_db_d   = r_db;
        w_stab_d = r_stab;
        for (int i = 0; i < 6; i++) begin
            if (r_sync2[i] == r_db[i]) begin
                w_stab_d[i] = '0;
            end else if (r_stab[i] == DebLast) begin
                w_db_d[i]   = ~r_db[i];
                w_stab_d[i] = '0;
            end else begin
                w_stab_d[i] = r_stab[i] + 8'd1;
            end
        end
    end

    // Debounced levels and registered one-cycle press events.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_db      <= '0;
            r_stab    <= '0;
            r_db_prev <= '0;
            r_pe      <= '0;
        end else begin
            r_db      <= w_db_d;
            r_stab    <= w_stab_d;
            r_db_prev <= r_db;
            r_pe      <= r_db & ~r_db_prev;
        end
    end

    // Lowest-index press event wins the grant.
    always_comb begin
        w_grant = '0;
        for (int i = 5; i >= 0; i--) begin
            if (r_pe[i]) begin
                w_grant = 3'(i);
            end
        end
    end

    assign w_any_pe        = |r_pe;
    assign w_start         = ((r_state == StIdle) || (r_state == StShow)) && w_any_pe;
    // Look at the level being written this edge so the state enters COAST the same edge
    // the granted button's debounced level falls.
    assign w_db_g          = w_db_d[r_die_sel];
    assign w_coast_pulse   = (r_state == StCoast) && (r_wait == 8'd0);
    assign w_interval_next = r_interval[7] ? 8'd128 : {r_interval[6:0], 1'b0};

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_state_d = r_state;
        case (r_state)
            StIdle, StShow: begin
                if (w_any_pe) begin
                    w_state_d = StRoll;
                end
            end
            StRoll: begin
                if (!w_db_g) begin
                    w_state_d = StCoast;
                end
            end
            StCoast: begin
                if (w_coast_pulse && (r_steps == StepsLast)) begin
                    w_state_d = StShow;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    // Grant capture, load pulse and coast timing (wait counts down to zero, then pulses).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_die_sel  <= '0;
            r_load     <= 1'b0;
            r_interval <= 8'd1;
            r_wait     <= 8'd1;
            r_steps    <= '0;
        end else begin
            r_load <= w_start;
            if (w_start) begin
                r_die_sel <= w_grant;
            end
            if ((r_state == StRoll) && !w_db_g) begin
                r_interval <= 8'd1;
                r_wait     <= 8'd1;
                r_steps    <= '0;
            end else if (w_coast_pulse) begin
                r_interval <= w_interval_next;
                r_wait     <= w_interval_next - 8'd1;
                r_steps    <= r_steps + 4'd1;
            end else if (r_state == StCoast) begin
                r_wait <= r_wait - 8'd1;
            end
        end
    end

    // Outputs decoded from registered state only.
    always_comb begin
        die_sel      = r_die_sel;
        cnt_load     = r_load;
        busy         = (r_state == StRoll) || (r_state == StCoast);
        result_valid = (r_state == StShow);
        cnt_step     = ((r_state == StRoll) && !r_load && r_db[r_die_sel]) || w_coast_pulse;
    end

endmodule

// File: tb/tb_dice_roll_ctrl.sv
// Bench for dice_roll_ctrl: directed scenarios plus random button activity, every cycle
// compared against a behavioural model of the roll sequencer.
module tb_dice_roll_ctrl;

    localparam int DEB = 4;
    localparam int NST = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] btn_raw;
    logic [2:0] die_sel;
    logic       cnt_load;
    logic       cnt_step;
    logic       busy;
    logic       result_valid;

    dice_roll_ctrl #(
        .DEB_CYCLES (DEB),
        .COAST_STEPS(NST)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .btn_raw     (btn_raw),
        .die_sel     (die_sel),
        .cnt_load    (cnt_load),
        .cnt_step    (cnt_step),
        .busy        (busy),
        .result_valid(result_valid)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_err  = 0;
    int n_load = 0;
    int n_step = 0;
    int n_tick = 0;
    int last_load_tick = -1;
    int last_load_die  = -1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef enum int {MIdle, MRoll, MCoast, MShow} mstate_t;
    logic [5:0] m_s1, m_s2, m_db, m_rose, m_pe;
    logic [5:0] m_hist[$];
    mstate_t    m_st;
    int         m_die, m_cyc, m_t0;
    bit         m_load;

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_db = '0; m_rose = '0; m_pe = '0;
        m_hist.delete();
        m_st = MIdle; m_die = 0; m_load = 0; m_cyc = 0; m_t0 = 0;
    endtask

    // One clock edge of the model, using the inputs present at that edge.
    task automatic model_edge();
        logic [5:0] smp, db_old, pe_now;
        int g;
        bit all_diff;
        if (rst) begin
            model_reset();
            return;
        end
        m_cyc++;
        pe_now = m_pe;
        smp = m_s2;
        m_s2 = m_s1;
        m_s1 = btn_raw;
        m_hist.push_back(smp);
        if (m_hist.size() > DEB) void'(m_hist.pop_front());
        db_old = m_db;
        if (m_hist.size() == DEB) begin
            for (int i = 0; i < 6; i++) begin
                all_diff = 1;
                foreach (m_hist[j]) if (m_hist[j][i] == db_old[i]) all_diff = 0;
                if (all_diff) m_db[i] = ~db_old[i];
            end
        end
        m_pe   = m_rose;
        m_rose = m_db & ~db_old;
        m_load = 0;
        case (m_st)
            MIdle, MShow: begin
                if (pe_now != 0) begin
                    g = 0;
                    for (int i = 5; i >= 0; i--) if (pe_now[i]) g = i;
                    m_die  = g;
                    m_load = 1;
                    m_st   = MRoll;
                end
            end
            MRoll: begin
                if (!m_db[m_die]) begin
                    m_st = MCoast;
                    m_t0 = m_cyc;
                end
            end
            MCoast: if (m_cyc - m_t0 == (1 << NST)) m_st = MShow;
            default: ;
        endcase
    endtask

    // Expected {die_sel, cnt_load, cnt_step, busy, result_valid} for the current cycle.
    function automatic logic [6:0] model_exp();
        bit stp;
        int c;
        stp = 0;
        if (m_st == MRoll) stp = !m_load && m_db[m_die];
        if (m_st == MCoast) begin
            c   = m_cyc - m_t0;
            stp = (c >= 1) && (((c + 1) & c) == 0);
        end
        return {3'(m_die), m_load, stp, (m_st == MRoll) || (m_st == MCoast), m_st == MShow};
    endfunction

    function automatic logic [31:0] outs();
        return 32'({die_sel, cnt_load, cnt_step, busy, result_valid});
    endfunction

    task automatic tick(input logic [5:0] b);
        btn_raw = b;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_eq("outs", outs(), 32'(model_exp()));
        if (cnt_load) begin
            n_load++;
            last_load_tick = n_tick;
            last_load_die  = int'(die_sel);
        end
        if (cnt_step) n_step++;
        n_tick++;
    endtask

    task automatic ticks(input logic [5:0] b, input int n);
        for (int k = 0; k < n; k++) tick(b);
    endtask

    task automatic run_until_show(input logic [5:0] b, input int budget);
        int k = 0;
        while (!result_valid && k < budget) begin
            tick(b);
            k++;
        end
        check_eq("show_reached", 32'(result_valid), 32'd1);
    endtask

    initial begin
        int load0, step0, press_tick, k, r;
        logic [5:0] b;
        model_reset();

        // 1: reset held with all buttons pressed
        rst = 1'b1;
        ticks(6'h3F, 10);
        rst = 1'b0;
        load0 = n_load;
        ticks(6'h00, 20);
        check_eq("rst_no_load", 32'(n_load - load0), 32'd0);

        // 2: single d6 roll
        load0 = n_load;
        press_tick = n_tick;
        ticks(6'h02, 20);
        check_eq("d6_load_latency", 32'(last_load_tick - press_tick + 1), 32'(DEB + 4));
        check_eq("d6_die", 32'(last_load_die), 32'd1);
        run_until_show(6'h00, 60);
        check_eq("d6_loads", 32'(n_load - load0), 32'd1);
        ticks(6'h00, 5);

        // 3: simultaneous d20 + d100
        load0 = n_load;
        ticks(6'h30, 12);
        run_until_show(6'h00, 60);
        check_eq("arb_die", 32'(die_sel), 32'd4);
        check_eq("arb_loads", 32'(n_load - load0), 32'd1);
        ticks(6'h00, 5);

        // 4: interference during ROLL and COAST
        load0 = n_load;
        ticks(6'h01, 12);
        ticks(6'h21, 10);
        ticks(6'h01, 8);
        ticks(6'h00, DEB + 2);
        ticks(6'h08, 12);
        run_until_show(6'h08, 40);
        check_eq("intf_loads", 32'(n_load - load0), 32'd1);
        check_eq("intf_die", 32'(die_sel), 32'd0);
        ticks(6'h00, 12);
        check_eq("intf_loads_after", 32'(n_load - load0), 32'd1);

        // 5: bounce on d10, then a clean press
        load0 = n_load;
        for (int p = 0; p < 10; p++) begin
            ticks(6'h08, 3);
            ticks(6'h00, 2);
        end
        check_eq("bounce_loads", 32'(n_load - load0), 32'd0);
        ticks(6'h08, 10);
        run_until_show(6'h00, 60);
        check_eq("bounce_die", 32'(die_sel), 32'd3);
        check_eq("bounce_loads_after", 32'(n_load - load0), 32'd1);
        ticks(6'h00, 5);

        // 6: reset at COAST entry + 2
        ticks(6'h02, 10);
        k = 0;
        while (!(m_st == MCoast && m_cyc - m_t0 == 2) && k < 60) begin
            tick(6'h00);
            k++;
        end
        check_eq("coast_plus2_reached", 32'(m_st == MCoast && m_cyc - m_t0 == 2), 32'd1);
        rst = 1'b1;
        #1;
        check_eq("async_rst_outs", outs(), 32'd0);
        model_reset();
        ticks(6'h00, 3);
        rst = 1'b0;
        step0 = n_step;
        ticks(6'h00, 300);
        check_eq("post_rst_steps", 32'(n_step - step0), 32'd0);

        // random activity
        for (int ep = 0; ep < 50; ep++) begin
            r = int'($urandom_range(0, 4));
            case (r)
                0: ticks(6'($urandom_range(1, 63)), int'($urandom_range(1, 25)));
                1: ticks(6'($urandom_range(1, 63)), int'($urandom_range(1, DEB - 1)));
                2: ticks(6'h00, int'($urandom_range(1, 30)));
                3: begin
                    b = 6'h01 << $urandom_range(0, 5);
                    ticks(b, int'($urandom_range(5, 20)));
                    ticks(6'h00, int'($urandom_range(0, 15)));
                end
                default: begin
                    rst = 1'b1;
                    ticks(6'($urandom_range(0, 63)), 2);
                    rst = 1'b0;
                end
            endcase
        end
        ticks(6'h00, 40);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dice_roll_ctrl.md
# dice_roll_ctrl

Roll sequencer for the dice roller. Sits between the six die-select push buttons and the two-digit BCD down-counter datapath. Debounces the buttons and grants one roll at a time. Drives the counter's load/step controls through a hold phase and a decelerating coast phase, then flags the settled result for display.

## Interface

Parameters:
- DEB_CYCLES, 64: consecutive stable synchronized samples required to change a debounced button level (about 2 ms at 32768 Hz); legal range 2..255.
- COAST_STEPS, 8: number of step pulses issued after release; legal range 1..8.

Ports:
- clk, input, 1: single clock, 32768 Hz.
- rst, input, 1: asynchronous, active-high reset.
- btn_raw, input, 6: raw buttons, active high; bit 0..5 = d4, d6, d8, d10, d20, d100.
- die_sel, output, 3: granted die code 0..5 (same order as btn_raw).
- cnt_load, output, 1: one-cycle pulse; the counter loads its start value for die_sel.
- cnt_step, output, 1: one-cycle-per-step enable; the counter decrements and wraps once per high cycle.
- busy, output, 1: high in ROLL and COAST.
- result_valid, output, 1: high in SHOW; the counter value is final.

## Operation

- Input path, per bit: 2-flop synchronizer, then a debouncer.
  - The debouncer holds a level `db[i]` and an 8-bit stability counter.
  - The counter resets whenever the synchronized value equals `db[i]`.
  - `db[i]` toggles when the synchronized value has differed for DEB_CYCLES consecutive cycles.
  - Press event `pe[i]` = rising edge of `db[i]`, registered, one cycle wide.
- FSM states: IDLE, ROLL, COAST, SHOW.
- IDLE / SHOW:
  - On any `pe`, grant g = lowest index with `pe` set.
  - Register die_sel = g, pulse cnt_load, go to ROLL.
  - Held levels without an event never start a roll.
- ROLL:
  - cnt_step = 1 every cycle while `db[g]` = 1.
  - Other buttons and events are ignored.
  - When `db[g]` = 0, go to COAST with interval = 1, wait = 1, steps = 0; cnt_step = 0 that cycle.
- COAST:
  - Each cycle, wait decrements.
  - When wait reaches 0: pulse cnt_step, steps += 1, interval doubles (8-bit, max 128), wait = new interval.
  - After the COAST_STEPS-th pulse, go to SHOW.
  - All button events are ignored.
- SHOW: result_valid = 1 until the next press event, which behaves as in IDLE.
- cnt_load and cnt_step are never high in the same cycle.
- die_sel changes only on a grant.

## Timing

- Reset values:
  - state IDLE; die_sel 0; cnt_load 0; cnt_step 0; busy 0; result_valid 0.
  - All `db` levels 0, stability counters 0, synchronizers 0.
- Reset is honoured mid-roll: all outputs drop asynchronously, and no step pulses follow deassertion.
- Press latency: btn_raw rising and held stable → `pe` high DEB_CYCLES+3 cycles later (2 sync, DEB_CYCLES count, 1 edge register).
- Grant latency: cnt_load, die_sel and busy are all registered and high the cycle after `pe`.
  - result_valid falls in that same cycle.
- cnt_step in ROLL starts the cycle after cnt_load.
- Release latency: btn_raw falling and held → `db[g]` falls DEB_CYCLES+2 cycles later. The last ROLL step is the cycle before the state becomes COAST.
- COAST step pulses: relative to COAST entry cycle 0, pulses at cycles 1, 3, 7, 15, … (2^k − 1).
  - With COAST_STEPS = 8, the last pulse is at cycle 255.
  - result_valid and busy = 0 occur at cycle 256.
- Glitches shorter than DEB_CYCLES cycles never change `db`.
- Simultaneous press events: lowest index wins; the losers are discarded, not queued.

## Test plan

All scenarios use DEB_CYCLES = 4 and COAST_STEPS = 3.

1. Reset check: assert rst with btn_raw = 6'h3F, hold 10 cycles. All outputs stay 0 throughout. After release, no cnt_load occurs because no rising edge is seen.
2. Single roll, d6: btn_raw = 6'h02 for 20 cycles, then 0.
   - cnt_load is high at cycle 8 after the press, with die_sel = 1.
   - cnt_step runs continuously through the hold.
   - Coast pulses land at COAST-entry +1, +3, +7.
   - result_valid rises at +8, and busy falls in the same cycle.
3. Arbitration: btn_raw 0 → 6'h30 (d20 and d100 on the same cycle). Required: die_sel = 4 and exactly one cnt_load.
4. Interference: during ROLL on d4, pulse d100; then release d4 and press d10 during COAST. Required: no second cnt_load; die_sel stays 0 through SHOW.
5. Bounce: 3-cycle glitches on btn_raw[3], every 5 cycles, for 50 cycles. Required: no `pe`, no cnt_load. A stable 10-cycle press afterwards gives exactly one roll with die_sel = 3.
6. Mid-roll reset: assert rst at COAST entry +2. Required: outputs 0 immediately; no cnt_step for 300 cycles after deassertion with buttons idle.
